// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE status flags plus sizing helpers for the writeback result buffer.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    localparam int unsigned WB_DEFAULT_DEPTH = 4;

    // Occupancy needs one extra bit so that "full" (count == depth) is representable.
    function automatic int unsigned wb_cnt_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fpnew_wb_buffer.sv
// In-order writeback result buffer behind an FPU opgroup, accumulating sticky fflags of retired results.
// Optional FPNEW_WB_BYPASS_EN: zero-latency pass-through while empty and writeback is ready.
module fpnew_wb_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = WB_DEFAULT_DEPTH,
    parameter type         TagType = logic
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [Width-1:0]              result_i,
    input  status_t                       status_i,
    input  logic                          extension_bit_i,
    input  TagType                        tag_i,
    input  logic                          flush_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [Width-1:0]              result_o,
    output status_t                       status_o,
    output logic                          extension_bit_o,
    output TagType                        tag_o,
    output status_t                       fflags_o,
    input  logic                          fflags_clr_i,
    output logic [wb_cnt_bits(Depth)-1:0] count_o,
    output logic                          busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = wb_cnt_bits(Depth);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
    } entry_t;

    entry_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic [4:0]      fflags;

    entry_t in_entry;
    entry_t empty_head;
    entry_t head;
    logic   empty;
    logic   full;
    logic   bypass;
    logic   do_push;
    logic   do_pop;
    logic   retire;

    assign in_entry = '{result: result_i, status: status_i, ext_bit: extension_bit_i, tag: tag_i};

    // Full/empty come from the occupancy counter; pointers alone cannot tell them apart.
    assign empty      = (count == '0);
    assign full       = (count == CntW'(Depth));
    assign in_ready_o = !full;

`ifdef FPNEW_WB_BYPASS_EN
    assign bypass      = empty && in_valid_i && out_ready_i && !flush_i;
    assign out_valid_o = empty ? (in_valid_i && !flush_i) : 1'b1;
    assign empty_head  = in_entry;
`else
    assign bypass      = 1'b0;
    assign out_valid_o = !empty;
    assign empty_head  = '0;
`endif

    // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
    always_comb begin
        head = empty_head;
        if (!empty) head = mem[rd_ptr];
    end

    assign do_push = in_valid_i && in_ready_o && !bypass && !flush_i;
    assign do_pop  = out_valid_o && out_ready_i && !empty;
    assign retire  = out_valid_o && out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (fflags_clr_i) fflags <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
            // A clear in the same cycle as a retirement drops old flags but keeps the new ones.
            if (retire) begin
                fflags <= (fflags_clr_i ? 5'b0 : fflags) | head.status;
            end else if (fflags_clr_i) begin
                fflags <= '0;
            end
        end
    end

    // NOTE: storage has no reset; validity is defined by the counter and empty reads are masked.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= in_entry;
    end

    assign result_o        = head.result;
    assign status_o        = head.status;
    assign extension_bit_o = head.ext_bit;
    assign tag_o           = head.tag;
    assign fflags_o        = status_t'(fflags);
    assign count_o         = count;
    assign busy_o          = !empty;

endmodule
